// File: rtl/cardinal_ex_sequencer.sv
// Cardinal EX-stage sequencer: latency-driven stall, hazard flags and registered writeback.
// Optional perf counters are built when CARDINAL_EXSEQ_PERF_EN is defined.
module cardinal_ex_sequencer #(
   parameter int DATA_WIDTH     = 64,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int LAT_SINGLE     = 1,
   parameter int LAT_MEM        = 2,
   parameter int LAT_ADDSUB     = 3,
   parameter int LAT_MULSQ      = 4,
   parameter int LAT_DIVSQRT    = 5,
   parameter int LAT_SHIFT      = 3,
   parameter int CNT_WIDTH      = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      issue_valid,
   output logic                      issue_ready,
   input  logic [2:0]                issue_class,
   input  logic [REG_ADDR_WIDTH-1:0] issue_rd,
   input  logic                      issue_wr_en,
   input  logic [2:0]                issue_ppp,
   input  logic [DATA_WIDTH-1:0]     res_data_in,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs0,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1,
   output logic                      hazard0,
   output logic                      hazard1,
   output logic                      stall,
   output logic                      busy,
   output logic                      wb_valid,
   output logic [REG_ADDR_WIDTH-1:0] wb_rd,
   output logic [DATA_WIDTH-1:0]     wb_data,
   output logic [DATA_WIDTH/8-1:0]   wb_mask,
   output logic [31:0]               perf_stall_cycles,
   output logic [31:0]               perf_ops_retired
);

   // state | meaning
   // IDLE  | nothing in flight, any op is accepted
   // BUSY  | op in flight; cnt counts down, cnt==0 is its completion cycle
   localparam int NB = DATA_WIDTH / 8;

   localparam logic [CNT_WIDTH-1:0] LAT_SINGLE_M1  = CNT_WIDTH'(LAT_SINGLE - 1);
   localparam logic [CNT_WIDTH-1:0] LAT_MEM_M1     = CNT_WIDTH'(LAT_MEM - 1);
   localparam logic [CNT_WIDTH-1:0] LAT_ADDSUB_M1  = CNT_WIDTH'(LAT_ADDSUB - 1);
   localparam logic [CNT_WIDTH-1:0] LAT_MULSQ_M1   = CNT_WIDTH'(LAT_MULSQ - 1);
   localparam logic [CNT_WIDTH-1:0] LAT_DIVSQRT_M1 = CNT_WIDTH'(LAT_DIVSQRT - 1);
   localparam logic [CNT_WIDTH-1:0] LAT_SHIFT_M1   = CNT_WIDTH'(LAT_SHIFT - 1);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
   logic [REG_ADDR_WIDTH-1:0] inf_rd_q, inf_rd_d;
   logic                      inf_wr_en_q, inf_wr_en_d;
   logic [2:0]                inf_ppp_q, inf_ppp_d;
   logic                      wb_valid_q, wb_valid_d;
   logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
   logic [DATA_WIDTH-1:0]     wb_data_q, wb_data_d;
   logic [NB-1:0]             wb_mask_q, wb_mask_d;

   logic                      accept;
   logic                      complete;
   logic                      inf_writes;
   logic [CNT_WIDTH-1:0]      lat_m1;
   logic [NB-1:0]             ppp_mask;

   assign busy        = (state_q == ST_BUSY);
   assign issue_ready = !flush && ((state_q == ST_IDLE) || (cnt_q == '0));
   assign accept      = issue_valid && issue_ready;
   assign stall       = issue_valid && !issue_ready;
   assign complete    = busy && (cnt_q == '0) && !flush;
   assign inf_writes  = inf_wr_en_q && (inf_rd_q != '0);
   assign hazard0     = busy && inf_writes && (inf_rd_q == id_rs0);
   assign hazard1     = busy && inf_writes && (inf_rd_q == id_rs1);

   assign wb_valid = wb_valid_q;
   assign wb_rd    = wb_rd_q;
   assign wb_data  = wb_data_q;
   assign wb_mask  = wb_mask_q;

   always_comb begin
      case (issue_class)
         3'd0:    lat_m1 = LAT_SINGLE_M1;
         3'd1:    lat_m1 = LAT_MEM_M1;
         3'd2:    lat_m1 = LAT_ADDSUB_M1;
         3'd3:    lat_m1 = LAT_MULSQ_M1;
         3'd4:    lat_m1 = LAT_DIVSQRT_M1;
         3'd5:    lat_m1 = LAT_SHIFT_M1;
         default: lat_m1 = LAT_SINGLE_M1;
      endcase
   end

   // Mask bit NB-1 is the most significant byte lane; u/d pick halves, e/o alternate lanes.
   always_comb begin
      ppp_mask = '0;
      for (int i = 0; i < NB; i++) begin
         case (inf_ppp_q)
            3'b000:  ppp_mask[i] = 1'b1;
            3'b001:  ppp_mask[i] = (i >= NB / 2);
            3'b010:  ppp_mask[i] = (i < NB / 2);
            3'b011:  ppp_mask[i] = (i % 2 == 1);
            3'b100:  ppp_mask[i] = (i % 2 == 0);
            default: ppp_mask[i] = 1'b0;
         endcase
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      inf_rd_d    = inf_rd_q;
      inf_wr_en_d = inf_wr_en_q;
      inf_ppp_d   = inf_ppp_q;
      wb_valid_d  = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      wb_mask_d   = wb_mask_q;

      if (flush) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else begin
         if (busy && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
         end
         if (complete) begin
            wb_valid_d = inf_writes;
            wb_rd_d    = inf_rd_q;
            wb_data_d  = res_data_in;
            wb_mask_d  = ppp_mask;
            state_d    = ST_IDLE;
         end
         // A new op may be accepted on the completion edge; it overrides the IDLE return.
         if (accept) begin
            inf_rd_d    = issue_rd;
            inf_wr_en_d = issue_wr_en;
            inf_ppp_d   = issue_ppp;
            cnt_d       = lat_m1;
            state_d     = ST_BUSY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         inf_rd_q    <= '0;
         inf_wr_en_q <= 1'b0;
         inf_ppp_q   <= '0;
         wb_valid_q  <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         wb_mask_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         inf_rd_q    <= inf_rd_d;
         inf_wr_en_q <= inf_wr_en_d;
         inf_ppp_q   <= inf_ppp_d;
         wb_valid_q  <= wb_valid_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         wb_mask_q   <= wb_mask_d;
      end
   end

`ifdef CARDINAL_EXSEQ_PERF_EN
   logic [31:0] perf_stall_q, perf_stall_d;
   logic [31:0] perf_ret_q, perf_ret_d;

   always_comb begin
      perf_stall_d = perf_stall_q;
      perf_ret_d   = perf_ret_q;
      if (stall && (perf_stall_q != 32'hFFFF_FFFF)) begin
         perf_stall_d = perf_stall_q + 32'd1;
      end
      if (complete && (perf_ret_q != 32'hFFFF_FFFF)) begin
         perf_ret_d = perf_ret_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stall_q <= '0;
         perf_ret_q   <= '0;
      end else begin
         perf_stall_q <= perf_stall_d;
         perf_ret_q   <= perf_ret_d;
      end
   end

   assign perf_stall_cycles = perf_stall_q;
   assign perf_ops_retired  = perf_ret_q;
`else
   assign perf_stall_cycles = 32'd0;
   assign perf_ops_retired  = 32'd0;
`endif

endmodule

// File: tb/tb_cardinal_ex_sequencer.sv
// Scoreboard bench for cardinal_ex_sequencer: directed scenarios followed by random traffic.
module tb_cardinal_ex_sequencer;

   logic        clk = 1'b0;
   logic        reset, flush, issue_valid, issue_ready, issue_wr_en;
   logic [2:0]  issue_class, issue_ppp;
   logic [4:0]  issue_rd, id_rs0, id_rs1, wb_rd;
   logic [63:0] res_data_in, wb_data;
   logic [7:0]  wb_mask;
   logic        hazard0, hazard1, stall, busy, wb_valid;
   logic [31:0] perf_stall_cycles, perf_ops_retired;

   always #5 clk = ~clk;

   cardinal_ex_sequencer dut (
      .clk(clk), .reset(reset), .flush(flush),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_class(issue_class),
      .issue_rd(issue_rd), .issue_wr_en(issue_wr_en), .issue_ppp(issue_ppp),
      .res_data_in(res_data_in), .id_rs0(id_rs0), .id_rs1(id_rs1),
      .hazard0(hazard0), .hazard1(hazard1), .stall(stall), .busy(busy),
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_mask(wb_mask),
      .perf_stall_cycles(perf_stall_cycles), .perf_ops_retired(perf_ops_retired)
   );

   typedef struct {
      int          due;
      bit          wv;
      logic [4:0]  rd;
      logic [63:0] data;
      logic [7:0]  mask;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;

   // reference model state
   bit          m_busy;
   int          m_done;
   logic [4:0]  m_rd;
   bit          m_wr;
   logic [63:0] m_data;
   logic [4:0]  m_wb_rd;
   logic [63:0] m_wb_data;
   logic [7:0]  m_wb_mask;
   longint      m_stalls, m_retired;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic int lat_of(input logic [2:0] c);
      case (c)
         3'd0: return 1;
         3'd1: return 2;
         3'd2: return 3;
         3'd3: return 4;
         3'd4: return 5;
         3'd5: return 3;
         default: return 1;
      endcase
   endfunction

   function automatic logic [7:0] mask_of(input logic [2:0] p);
      case (p)
         3'b000: return 8'hFF;
         3'b001: return 8'hF0;
         3'b010: return 8'h0F;
         3'b011: return 8'hAA;
         3'b100: return 8'h55;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_clear();
      m_busy = 0; m_done = 0; m_rd = '0; m_wr = 0;
      m_wb_rd = '0; m_wb_data = '0; m_wb_mask = '0;
      m_stalls = 0; m_retired = 0;
      sb.delete();
   endtask

   // One clock cycle: drive at negedge, check combinational outputs, advance the model to the next edge.
   task automatic cyc(input bit rst, input bit fl, input bit iv, input logic [2:0] cls,
                      input logic [4:0] rd, input bit wr, input logic [2:0] ppp,
                      input logic [4:0] rs0, input logic [4:0] rs1);
      int   e;
      bit   rdy, stl, hz0, hz1, wr_eff;
      exp_t ent;
      @(negedge clk);
      reset = rst; flush = fl; issue_valid = iv; issue_class = cls; issue_rd = rd;
      issue_wr_en = wr; issue_ppp = ppp; id_rs0 = rs0; id_rs1 = rs1;
      res_data_in = m_data;
      #1;
      e   = edge_n + 1;
      rdy = !fl && (!m_busy || m_done == e);
      stl = iv && !rdy;
      wr_eff = m_busy && m_wr && (m_rd != 0);
      hz0 = wr_eff && (m_rd == rs0);
      hz1 = wr_eff && (m_rd == rs1);
      if (!rst) begin
         check("ctrl{ready,stall,busy,hz0,hz1}", {issue_ready, stall, busy, hazard0, hazard1},
               {rdy, stl, m_busy, hz0, hz1});
         check("wb_hold", {wb_rd, wb_data, wb_mask}, {m_wb_rd, m_wb_data, m_wb_mask});
      end
      if (rst) begin
         model_clear();
      end else begin
         if (stl) m_stalls++;
         if (fl) begin
            if (m_busy) void'(sb.pop_back());
            m_busy = 0;
         end else if (m_busy && m_done == e) begin
            m_retired++;
            m_busy    = 0;
            m_wb_rd   = m_rd;
            m_wb_data = m_data;
            m_wb_mask = sb[$].mask;
         end
         if (iv && rdy) begin
            m_busy   = 1;
            m_done   = e + lat_of(cls);
            m_rd     = rd;
            m_wr     = wr;
            m_data   = {$urandom(), $urandom()};
            ent.due  = m_done;
            ent.wv   = wr && (rd != 0);
            ent.rd   = rd;
            ent.data = m_data;
            ent.mask = mask_of(ppp);
            sb.push_back(ent);
         end
      end
   endtask

   // Monitor: on every edge, pop the entry due now or require wb_valid low.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         edge_n++;
         while (sb.size() > 0 && sb[0].due < edge_n) begin
            x = sb.pop_front();
            check("sb_stale_entry", edge_n, x.due);
         end
         if (sb.size() > 0 && sb[0].due == edge_n) begin
            x = sb.pop_front();
            check("wb_valid", wb_valid, x.wv);
            check("wb_fields", {wb_rd, wb_data, wb_mask}, {x.rd, x.data, x.mask});
         end else begin
            check("wb_valid_idle", wb_valid, 1'b0);
         end
      end
   end

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 3'd0, 5'd0, 0, 3'd0, 5'd0, 5'd0);
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 3'd0, 5'd0, 0, 3'd0, 5'd0, 5'd0);
      cyc(1, 0, 0, 3'd0, 5'd0, 0, 3'd0, 5'd0, 5'd0);
   endtask

   task automatic check_perf(input string tag);
`ifdef CARDINAL_EXSEQ_PERF_EN
      check({tag, "_perf_stall"}, perf_stall_cycles, m_stalls[31:0]);
      check({tag, "_perf_retired"}, perf_ops_retired, m_retired[31:0]);
`else
      check({tag, "_perf_stall"}, perf_stall_cycles, 32'd0);
      check({tag, "_perf_retired"}, perf_ops_retired, 32'd0);
`endif
   endtask

   initial begin
      reset = 1; flush = 0; issue_valid = 0; issue_class = 0; issue_rd = 0; issue_wr_en = 0;
      issue_ppp = 0; id_rs0 = 0; id_rs1 = 0; res_data_in = 0;
      m_data = 64'h0123456789ABCDEF;
      model_clear();
      do_reset();
      idle(1);
      check("reset_outputs", {wb_valid, wb_rd, wb_data, wb_mask, perf_stall_cycles, perf_ops_retired},
            '0);

      // scenario 1: class-2 op, issue_valid held through two stall cycles
      cyc(0, 0, 1, 3'd2, 5'd5, 1, 3'b000, 5'd0, 5'd0);
      m_data = 64'h0123456789ABCDEF;
      sb[$].data = m_data;
      cyc(0, 0, 1, 3'd2, 5'd6, 1, 3'b000, 5'd0, 5'd0);
      cyc(0, 0, 1, 3'd2, 5'd6, 1, 3'b000, 5'd0, 5'd0);
      idle(3);

      // scenario 2: class-4 then class-0 back to back
      cyc(0, 0, 1, 3'd4, 5'd9, 1, 3'b000, 5'd9, 5'd1);
      for (int i = 0; i < 5; i++) cyc(0, 0, 1, 3'd0, 5'd10, 1, 3'b011, 5'd10, 5'd9);
      idle(3);
      check_perf("scen12");

      // scenario 3: PPP sweep on class-1 ops to rd=3
      for (int p = 1; p <= 7; p++) begin
         cyc(0, 0, 1, 3'd1, 5'd3, 1, 3'(p), 5'd3, 5'd0);
         idle(2);
      end

      // scenario 4: hazards on class-3 ops, then rd=0 and wr_en=0 variants
      cyc(0, 0, 1, 3'd3, 5'd7, 1, 3'b000, 5'd7, 5'd7);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 3'd0, 5'd0, 0, 3'd0, 5'd7, 5'd7);
      cyc(0, 0, 1, 3'd3, 5'd0, 1, 3'b000, 5'd0, 5'd0);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 3'd0, 5'd0, 0, 3'd0, 5'd0, 5'd0);
      cyc(0, 0, 1, 3'd3, 5'd7, 0, 3'b000, 5'd7, 5'd7);
      for (int i = 0; i < 4; i++) cyc(0, 0, 0, 3'd0, 5'd0, 0, 3'd0, 5'd7, 5'd7);

      // scenario 5: flush mid class-4 op with issue_valid high, then reset mid-op
      cyc(0, 0, 1, 3'd4, 5'd12, 1, 3'b000, 5'd12, 5'd0);
      cyc(0, 0, 1, 3'd1, 5'd13, 1, 3'b000, 5'd12, 5'd0);
      cyc(0, 1, 1, 3'd1, 5'd13, 1, 3'b000, 5'd12, 5'd0);
      cyc(0, 0, 1, 3'd1, 5'd13, 1, 3'b010, 5'd13, 5'd0);
      idle(3);
      cyc(0, 0, 1, 3'd4, 5'd14, 1, 3'b000, 5'd14, 5'd0);
      cyc(0, 0, 0, 3'd0, 5'd0, 0, 3'd0, 5'd14, 5'd0);
      cyc(1, 1, 1, 3'd2, 5'd15, 1, 3'b000, 5'd14, 5'd0);
      idle(1);
      check("reset_midop_outputs",
            {wb_valid, wb_rd, wb_data, wb_mask, busy, hazard0, issue_ready, perf_stall_cycles,
             perf_ops_retired}, {1'b0, 5'd0, 64'd0, 8'd0, 1'b0, 1'b0, 1'b1, 64'd0});
      idle(6);

      // random traffic
      for (int i = 0; i < 600; i++) begin
         cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 15) == 0),
             ($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      end
      idle(8);
      check_perf("final");
      check("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
